// File: rtl/mdu_iterative_if.sv
// Request/response bundle between the EXU and the iterative M-extension unit.
// Ports: flush, in_valid/in_ready/mulctr/src1/src2, out_valid/out_ready/result.
interface mdu_iterative_if #(
    parameter int XLEN = 64
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      mulctr;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output flush, in_valid, mulctr, src1, src2, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  flush, in_valid, mulctr, src1, src2, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative RV64M unit: radix-2 shift-add multiply, radix-2 restoring divide.
// Ports: clk, rst (sync, active-high), bus (slave side of mdu_iterative_if).
module mdu_iterative #(
    parameter int XLEN = 64
) (
    input  logic           clk,
    input  logic           rst,
    mdu_iterative_if.slave bus
);
    localparam int H = XLEN / 2;
    localparam logic [6:0] NFULL = 7'(XLEN);
    localparam logic [6:0] NHALF = 7'(H);
    localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(H+1){1'b1}}, {(H-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [6:0]          cnt_q, cnt_d;
    logic                neg_q, neg_d;
    logic [2*XLEN-1:0]   mcand_q, mcand_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic [XLEN-1:0]     mplier_q, mplier_d;
    logic [XLEN-1:0]     quo_q, quo_d;
    logic [XLEN-1:0]     rem_q, rem_d;
    logic [XLEN-1:0]     dvs_q, dvs_d;
    logic [XLEN-1:0]     result_q, result_d;

    // W results are sign-extended from the low half.
    function automatic logic [XLEN-1:0] wext(input logic [XLEN-1:0] x,
                                             input logic w);
        wext = w ? {{H{x[H-1]}}, x[H-1:0]} : x;
    endfunction

    logic [3:0]      op;
    logic            w, is_div, is_nop, sx, s1, s2, neg1, neg2, dz, ovf;
    logic [XLEN-1:0] e1, e2, mag1, mag2, fast_res;

    // Decode of the incoming request; s1/s2 say which operands are signed.
    always_comb begin
        op     = bus.mulctr;
        w      = op[3];
        is_div = op[2];
        is_nop = op[3] & ~op[2] & (op[1:0] != 2'b00);
        sx     = w & is_div & ~op[0];
        s1     = is_div ? ~op[0] : (~w & (op[1:0] != 2'b11));
        s2     = is_div ? ~op[0] : (~w & ~op[1]);
        e1     = w ? {{H{sx & bus.src1[H-1]}}, bus.src1[H-1:0]} : bus.src1;
        e2     = w ? {{H{sx & bus.src2[H-1]}}, bus.src2[H-1:0]} : bus.src2;
        neg1   = s1 & e1[XLEN-1];
        neg2   = s2 & e2[XLEN-1];
        mag1   = neg1 ? -e1 : e1;
        mag2   = neg2 ? -e2 : e2;
        dz     = is_div & (e2 == '0);
        ovf    = is_div & ~op[0] & (&e2) & (e1 == (w ? MIN_W : MIN_D));
        fast_res = '0;
        if (dz) begin
            fast_res = wext(op[1] ? e1 : {XLEN{1'b1}}, w);
        end else if (ovf) begin
            fast_res = wext(op[1] ? {XLEN{1'b0}} : e1, w);
        end
    end

    logic [2*XLEN-1:0] prod_nx, pn;
    logic [XLEN:0]     shl, diff;
    logic              qbit;
    logic [XLEN-1:0]   rem_nx, quo_nx, dsel, mres, dres, fin;

    // One iteration of both datapaths plus the final sign fix-up.
    always_comb begin
        prod_nx = prod_q + (mplier_q[0] ? mcand_q : '0);
        shl     = {rem_q, quo_q[XLEN-1]};
        diff    = shl - {1'b0, dvs_q};
        qbit    = ~diff[XLEN];
        rem_nx  = qbit ? diff[XLEN-1:0] : shl[XLEN-1:0];
        quo_nx  = {quo_q[XLEN-2:0], qbit};
        pn      = neg_q ? -prod_nx : prod_nx;
        if (op_q[3]) begin
            mres = wext(pn[XLEN-1:0], 1'b1);
        end else if (op_q[1:0] == 2'b00) begin
            mres = pn[XLEN-1:0];
        end else begin
            mres = pn[2*XLEN-1:XLEN];
        end
        dsel = op_q[1] ? rem_nx : quo_nx;
        dres = wext(neg_q ? -dsel : dsel, op_q[3]);
        fin  = op_q[2] ? dres : mres;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && !bus.flush) begin
                    op_d     = op;
                    // Remainder takes the dividend sign only.
                    neg_d    = (is_div & op[1]) ? neg1 : (neg1 ^ neg2);
                    mcand_d  = {{XLEN{1'b0}}, mag1};
                    mplier_d = mag2;
                    prod_d   = '0;
                    // W dividends start in the top half so 32 steps suffice.
                    quo_d    = w ? (mag1 << H) : mag1;
                    rem_d    = '0;
                    dvs_d    = mag2;
                    cnt_d    = w ? NHALF : NFULL;
                    if (is_nop | dz | ovf) begin
                        result_d = fast_res;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                prod_d   = prod_nx;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                quo_d    = quo_nx;
                rem_d    = rem_nx;
                cnt_d    = cnt_q - 7'd1;
                if (cnt_q == 7'd1) begin
                    result_d = fin;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    // A flushed result must never complete a handshake.
    assign bus.out_valid = (state_q == DONE) && !bus.flush;
    assign bus.result    = result_q;
endmodule
